// File: rtl/if_prefetch_buffer_if.sv
// if_prefetch_buffer_if: fetch-side and decode-side handshake bundle for the prefetch buffer
interface if_prefetch_buffer_if #(parameter int DEPTH = 4);
  localparam int AW = $clog2(DEPTH);
  logic          in_valid;
  logic [31:0]   in_PC;
  logic [31:0]   in_Instruction;
  logic          in_ready;
  logic          freeze;
  logic          flush;
  logic          out_valid;
  logic [31:0]   PC;
  logic [31:0]   Instruction;
  logic [AW:0]   count;
  modport master (
    output in_valid, in_PC, in_Instruction, freeze, flush,
    input  in_ready, out_valid, PC, Instruction, count
  );
  modport slave (
    input  in_valid, in_PC, in_Instruction, freeze, flush,
    output in_ready, out_valid, PC, Instruction, count
  );
endinterface

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: in-order {PC,Instruction} queue between IF and the IF/ID register
module if_prefetch_buffer #(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  if_prefetch_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          enq, deq;
  // Outputs depend on registered state only; no in_* to out path, no pass-through when full
  assign bus.in_ready            = count_q != FULL;
  assign bus.out_valid           = count_q != '0;
  assign {bus.PC, bus.Instruction} = bus.out_valid ? mem_q[rd_ptr_q] : 64'd0;
  assign bus.count               = count_q;
  // Next-state: flush wins over everything and drops the same-cycle word
  always_comb begin
    enq      = bus.in_valid & bus.in_ready & ~bus.flush;
    deq      = bus.out_valid & ~bus.freeze & ~bus.flush;
    wr_ptr_d = bus.flush ? '0 : wr_ptr_q + AW'(enq);
    rd_ptr_d = bus.flush ? '0 : rd_ptr_q + AW'(deq);
    count_d  = bus.flush ? '0 : count_q + (AW+1)'(enq) - (AW+1)'(deq);
  end
  // Pointer and occupancy state, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Entry storage is not reset; a wrapped count_d also catches underflow
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {bus.in_PC, bus.in_Instruction};
    if (rst) assert (count_d <= FULL);
  end
endmodule
